// File: rtl/tlb_op_seq_pkg.sv
// Shared definitions for the TLB operation sequencer: op bit positions,
// FSM states, field widths and the invalidate-op limit.
package tlb_op_seq_pkg;

   localparam int OP_SRCH = 4;
   localparam int OP_RD   = 3;
   localparam int OP_WR   = 2;
   localparam int OP_FILL = 1;
   localparam int OP_INV  = 0;

   localparam int OP_W   = 5;
   localparam int VPPN_W = 19;
   localparam int ASID_W = 10;

   localparam logic [OP_W-1:0] INVOP_MAX = 5'd6;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_SRCH = 3'd1,
      ST_RD   = 3'd2,
      ST_WR   = 3'd3,
      ST_INV  = 3'd4,
      ST_RESP = 3'd5
   } state_e;

   function automatic logic is_onehot(input logic [OP_W-1:0] v);
      return ($countones(v) == 32'd1);
   endfunction

endpackage

// File: rtl/tlb_op_seq_rand_idx.sv
// Free-running replacement index for TLB fills; counts every cycle and
// wraps from TLBNUM-1 back to 0.
module tlb_rand_idx #(
   parameter int TLBNUM = 16,
   localparam int IDXW = $clog2(TLBNUM)
) (
   input  logic            clk,
   input  logic            reset,
   output logic [IDXW-1:0] rand_idx
);

   logic [IDXW-1:0] cnt_q;
   logic [IDXW-1:0] cnt_d;

   // next count with explicit wrap so non-power-of-two sizes also work
   always_comb begin
      if (cnt_q == IDXW'(TLBNUM - 1)) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + IDXW'(1);
      end
   end

   // counter register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign rand_idx = cnt_q;

endmodule

// File: rtl/tlb_op_seq.sv
// TLB operation sequencer: accepts one request, spends a single cycle on the
// TLB action, then holds a response until it is consumed.
module tlb_op_seq
   import tlb_op_seq_pkg::*;
#(
   parameter int TLBNUM = 16,
   localparam int IDXW = $clog2(TLBNUM)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [OP_W-1:0]   req_op,
   input  logic [OP_W-1:0]   req_invop,
   input  logic [ASID_W-1:0] req_asid,
   input  logic [VPPN_W-1:0] req_va,
   input  logic [IDXW-1:0]   csr_tlbidx_index,
   input  logic [VPPN_W-1:0] csr_tlbehi_vppn,
   input  logic [ASID_W-1:0] csr_asid_asid,
   output logic [VPPN_W-1:0] s_vppn,
   output logic [ASID_W-1:0] s_asid,
   input  logic              s_found,
   input  logic [IDXW-1:0]   s_index,
   output logic              inv_valid,
   output logic [OP_W-1:0]   inv_op,
   output logic [IDXW-1:0]   r_index,
   input  logic              r_e,
   output logic              we,
   output logic [IDXW-1:0]   w_index,
   output logic              done_valid,
   input  logic              done_ready,
   output logic [OP_W-1:0]   done_op,
   output logic              done_found,
   output logic [IDXW-1:0]   done_index,
   output logic              done_re,
   output logic              done_err,
   input  logic              flush
);

   state_e            state_q, state_d;
   logic [OP_W-1:0]   op_q, op_d;
   logic [OP_W-1:0]   invop_q, invop_d;
   logic [ASID_W-1:0] asid_q, asid_d;
   logic [VPPN_W-1:0] va_q, va_d;
   logic [IDXW-1:0]   idx_q, idx_d;
   logic [VPPN_W-1:0] vppn_q, vppn_d;
   logic [ASID_W-1:0] casid_q, casid_d;
   logic [IDXW-1:0]   rnd_q, rnd_d;
   logic              found_q, found_d;
   logic [IDXW-1:0]   index_q, index_d;
   logic              re_q, re_d;
   logic              err_q, err_d;
   logic [IDXW-1:0]   rand_idx;

   tlb_rand_idx #(.TLBNUM(TLBNUM)) u_rand_idx (
      .clk      (clk),
      .reset    (reset),
      .rand_idx (rand_idx)
   );

   // next-state, capture and output decode; flush overrides at the end
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      invop_d  = invop_q;
      asid_d   = asid_q;
      va_d     = va_q;
      idx_d    = idx_q;
      vppn_d   = vppn_q;
      casid_d  = casid_q;
      rnd_d    = rnd_q;
      found_d  = found_q;
      index_d  = index_q;
      re_d     = re_q;
      err_d    = err_q;

      req_ready  = 1'b0;
      s_vppn     = '0;
      s_asid     = '0;
      inv_valid  = 1'b0;
      inv_op     = '0;
      r_index    = '0;
      we         = 1'b0;
      w_index    = '0;
      done_valid = 1'b0;
      done_op    = '0;
      done_found = 1'b0;
      done_index = '0;
      done_re    = 1'b0;
      done_err   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            req_ready = ~reset;
            if (req_valid && req_ready && !flush) begin
               op_d    = req_op;
               invop_d = req_invop;
               asid_d  = req_asid;
               va_d    = req_va;
               idx_d   = csr_tlbidx_index;
               vppn_d  = csr_tlbehi_vppn;
               casid_d = csr_asid_asid;
               rnd_d   = rand_idx;
               found_d = 1'b0;
               re_d    = 1'b0;
               index_d = '0;
               err_d   = 1'b0;
               if (!is_onehot(req_op)) begin
                  err_d   = 1'b1;
                  state_d = ST_RESP;
               end else if (req_op[OP_SRCH]) begin
                  state_d = ST_SRCH;
               end else if (req_op[OP_RD]) begin
                  index_d = csr_tlbidx_index;
                  state_d = ST_RD;
               end else if (req_op[OP_WR]) begin
                  index_d = csr_tlbidx_index;
                  state_d = ST_WR;
               end else if (req_op[OP_FILL]) begin
                  index_d = rand_idx;
                  state_d = ST_WR;
               end else begin
                  state_d = ST_INV;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SRCH: begin
            s_vppn  = vppn_q;
            s_asid  = casid_q;
            found_d = s_found;
            index_d = s_index;
            state_d = ST_RESP;
         end
         ST_RD: begin
            r_index = idx_q;
            re_d    = r_e;
            state_d = ST_RESP;
         end
         ST_WR: begin
            we      = 1'b1;
            w_index = op_q[OP_FILL] ? rnd_q : idx_q;
            state_d = ST_RESP;
         end
         ST_INV: begin
            if (invop_q <= INVOP_MAX) begin
               inv_valid = 1'b1;
               inv_op    = invop_q;
               s_asid    = asid_q;
               s_vppn    = va_q;
            end else begin
               err_d = 1'b1;
            end
            state_d = ST_RESP;
         end
         ST_RESP: begin
            done_valid = 1'b1;
            done_op    = op_q;
            done_found = found_q;
            done_index = index_q;
            done_re    = re_q;
            done_err   = err_q;
            if (done_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RESP;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // flush kills any side effect this cycle and abandons the operation
      if (flush) begin
         state_d    = ST_IDLE;
         we         = 1'b0;
         inv_valid  = 1'b0;
         done_valid = 1'b0;
      end else begin
         state_d = state_d;
      end
   end

   // state and captured request registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         op_q    <= '0;
         invop_q <= '0;
         asid_q  <= '0;
         va_q    <= '0;
         idx_q   <= '0;
         vppn_q  <= '0;
         casid_q <= '0;
         rnd_q   <= '0;
         found_q <= 1'b0;
         index_q <= '0;
         re_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         invop_q <= invop_d;
         asid_q  <= asid_d;
         va_q    <= va_d;
         idx_q   <= idx_d;
         vppn_q  <= vppn_d;
         casid_q <= casid_d;
         rnd_q   <= rnd_d;
         found_q <= found_d;
         index_q <= index_d;
         re_q    <= re_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_tlb_op_seq.sv
// Self-checking bench for tlb_op_seq: a vector table, hand-written flush and
// reset sequences, and random requests checked against a behavioural model.
module tb_tlb_op_seq;

   localparam int TLBNUM = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [4:0]  req_op = 5'd0;
   logic [4:0]  req_invop = 5'd0;
   logic [9:0]  req_asid = 10'd0;
   logic [18:0] req_va = 19'd0;
   logic [3:0]  csr_tlbidx_index = 4'd0;
   logic [18:0] csr_tlbehi_vppn = 19'd0;
   logic [9:0]  csr_asid_asid = 10'd0;
   logic [18:0] s_vppn;
   logic [9:0]  s_asid;
   logic        s_found = 1'b0;
   logic [3:0]  s_index = 4'd0;
   logic        inv_valid;
   logic [4:0]  inv_op;
   logic [3:0]  r_index;
   logic        r_e = 1'b0;
   logic        we;
   logic [3:0]  w_index;
   logic        done_valid;
   logic        done_ready = 1'b0;
   logic [4:0]  done_op;
   logic        done_found;
   logic [3:0]  done_index;
   logic        done_re;
   logic        done_err;
   logic        flush = 1'b0;

   int tests = 0;
   int fails = 0;
   int m_rand = 0;

   typedef struct {
      logic [4:0]  op;
      logic [4:0]  invop;
      logic [9:0]  asid;
      logic [18:0] va;
      logic [3:0]  cidx;
      logic [18:0] cvppn;
      logic [9:0]  casid;
      logic        sfound;
      logic [3:0]  sidx;
      logic        re;
   } req_t;

   typedef struct {
      int          lat;
      logic        we;
      logic [3:0]  w_index;
      logic        inv;
      logic [4:0]  inv_op;
      logic [18:0] s_vppn;
      logic [9:0]  s_asid;
      logic [3:0]  r_index;
      logic        found;
      logic [3:0]  index;
      logic        re;
      logic        err;
   } exp_t;

   typedef struct {
      req_t r;
      exp_t e;
   } vec_t;

   tlb_op_seq #(.TLBNUM(TLBNUM)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_invop(req_invop), .req_asid(req_asid), .req_va(req_va),
      .csr_tlbidx_index(csr_tlbidx_index), .csr_tlbehi_vppn(csr_tlbehi_vppn),
      .csr_asid_asid(csr_asid_asid),
      .s_vppn(s_vppn), .s_asid(s_asid), .s_found(s_found), .s_index(s_index),
      .inv_valid(inv_valid), .inv_op(inv_op),
      .r_index(r_index), .r_e(r_e), .we(we), .w_index(w_index),
      .done_valid(done_valid), .done_ready(done_ready), .done_op(done_op),
      .done_found(done_found), .done_index(done_index), .done_re(done_re),
      .done_err(done_err), .flush(flush)
   );

   always #5 clk = ~clk;

   // reference replacement counter: position modulo the TLB size
   always @(posedge clk or posedge reset) begin
      if (reset) m_rand <= 0;
      else       m_rand <= (m_rand + 1) % TLBNUM;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t model(input req_t r, input int rnd);
      exp_t e;
      e = '{default: 0};
      if ($countones(r.op) != 1) begin
         e.lat = 1;
         e.err = 1'b1;
         return e;
      end
      e.lat = 2;
      if (r.op[4]) begin
         e.s_vppn = r.cvppn; e.s_asid = r.casid; e.found = r.sfound; e.index = r.sidx;
      end else if (r.op[3]) begin
         e.r_index = r.cidx; e.re = r.re; e.index = r.cidx;
      end else if (r.op[2] || r.op[1]) begin
         e.we = 1'b1;
         e.w_index = r.op[1] ? 4'(rnd) : r.cidx;
         e.index = e.w_index;
      end else if (r.invop > 5'd6) begin
         e.err = 1'b1;
      end else begin
         e.inv = 1'b1; e.inv_op = r.invop; e.s_vppn = r.va; e.s_asid = r.asid;
      end
      return e;
   endfunction

   task automatic drive_req(input req_t r);
      req_valid = 1'b1;
      req_op = r.op; req_invop = r.invop; req_asid = r.asid; req_va = r.va;
      csr_tlbidx_index = r.cidx; csr_tlbehi_vppn = r.cvppn; csr_asid_asid = r.casid;
      s_found = r.sfound; s_index = r.sidx; r_e = r.re;
   endtask

   task automatic check_done(input req_t r, input exp_t e);
      chk("done_valid", done_valid, 1);
      chk("done_op", done_op, r.op);
      chk("done_found", done_found, e.found);
      chk("done_index", done_index, e.index);
      chk("done_re", done_re, e.re);
      chk("done_err", done_err, e.err);
   endtask

   task automatic run_txn(input req_t r, input exp_t e_in, input bit use_model, input int hold);
      exp_t e;
      bit   seen;
      @(negedge clk);
      e = use_model ? model(r, m_rand) : e_in;
      chk("ready_idle", req_ready, 1);
      drive_req(r);
      seen = 1'b0;
      for (int cyc = 1; cyc <= 8 && !seen; cyc++) begin
         @(negedge clk);
         req_valid = 1'b0;
         if (cyc == 1) begin
            chk("we", we, e.we);
            chk("w_index", w_index, e.w_index);
            chk("inv_valid", inv_valid, e.inv);
            chk("inv_op", inv_op, e.inv_op);
            chk("s_vppn", s_vppn, e.s_vppn);
            chk("s_asid", s_asid, e.s_asid);
            chk("r_index", r_index, e.r_index);
         end
         if (done_valid) begin
            seen = 1'b1;
            chk("latency", cyc, e.lat);
         end
      end
      if (!seen) begin
         tests++;
         fails++;
         $display("FAIL done_timeout: done_valid never rose, expected by cycle %0d", e.lat);
      end else begin
         for (int h = 0; h <= hold; h++) begin
            check_done(r, e);
            if (h == hold) done_ready = 1'b1;
            @(negedge clk);
         end
         done_ready = 1'b0;
         chk("done_drop", done_valid, 0);
         chk("ready_back", req_ready, 1);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[10];
      req_t r;
      exp_t ez;
      ez = '{default: 0};

      //            op        invop  asid     va          cidx   cvppn       casid    sf    sidx   re
      tbl[0] = '{'{5'b10000, 5'd0, 10'd0,   19'h00000, 4'd9,  19'h12345, 10'h003, 1'b1, 4'd5,  1'b0},
                 '{2, 1'b0, 4'd0,  1'b0, 5'd0, 19'h12345, 10'h003, 4'd0,  1'b1, 4'd5,  1'b0, 1'b0}};
      tbl[1] = '{'{5'b10000, 5'd0, 10'd0,   19'h00000, 4'd1,  19'h7FFFF, 10'h3FF, 1'b0, 4'hA,  1'b1},
                 '{2, 1'b0, 4'd0,  1'b0, 5'd0, 19'h7FFFF, 10'h3FF, 4'd0,  1'b0, 4'hA,  1'b0, 1'b0}};
      tbl[2] = '{'{5'b01000, 5'd0, 10'd0,   19'h00000, 4'd7,  19'h00001, 10'h001, 1'b1, 4'd3,  1'b1},
                 '{2, 1'b0, 4'd0,  1'b0, 5'd0, 19'h00000, 10'h000, 4'd7,  1'b0, 4'd7,  1'b1, 1'b0}};
      tbl[3] = '{'{5'b01000, 5'd0, 10'd0,   19'h00000, 4'hF,  19'h00000, 10'h000, 1'b0, 4'd0,  1'b0},
                 '{2, 1'b0, 4'd0,  1'b0, 5'd0, 19'h00000, 10'h000, 4'hF,  1'b0, 4'hF,  1'b0, 1'b0}};
      tbl[4] = '{'{5'b00100, 5'd0, 10'd0,   19'h00000, 4'hC,  19'h00000, 10'h000, 1'b1, 4'd2,  1'b1},
                 '{2, 1'b1, 4'hC,  1'b0, 5'd0, 19'h00000, 10'h000, 4'd0,  1'b0, 4'hC,  1'b0, 1'b0}};
      tbl[5] = '{'{5'b00001, 5'd5, 10'h02A, 19'h00ABC, 4'd4,  19'h11111, 10'h055, 1'b1, 4'd1,  1'b1},
                 '{2, 1'b0, 4'd0,  1'b1, 5'd5, 19'h00ABC, 10'h02A, 4'd0,  1'b0, 4'd0,  1'b0, 1'b0}};
      tbl[6] = '{'{5'b00001, 5'd6, 10'h001, 19'h7FFFF, 4'd4,  19'h00000, 10'h000, 1'b0, 4'd0,  1'b0},
                 '{2, 1'b0, 4'd0,  1'b1, 5'd6, 19'h7FFFF, 10'h001, 4'd0,  1'b0, 4'd0,  1'b0, 1'b0}};
      tbl[7] = '{'{5'b00001, 5'd7, 10'h02A, 19'h00ABC, 4'd4,  19'h00000, 10'h000, 1'b0, 4'd0,  1'b0},
                 '{2, 1'b0, 4'd0,  1'b0, 5'd0, 19'h00000, 10'h000, 4'd0,  1'b0, 4'd0,  1'b0, 1'b1}};
      tbl[8] = '{'{5'b00110, 5'd0, 10'd0,   19'h00000, 4'd6,  19'h00000, 10'h000, 1'b1, 4'd6,  1'b1},
                 '{1, 1'b0, 4'd0,  1'b0, 5'd0, 19'h00000, 10'h000, 4'd0,  1'b0, 4'd0,  1'b0, 1'b1}};
      tbl[9] = '{'{5'b00000, 5'd0, 10'd0,   19'h00000, 4'd6,  19'h00000, 10'h000, 1'b1, 4'd6,  1'b1},
                 '{1, 1'b0, 4'd0,  1'b0, 5'd0, 19'h00000, 10'h000, 4'd0,  1'b0, 4'd0,  1'b0, 1'b1}};

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_we", we, 0);
      chk("rst_inv_valid", inv_valid, 0);
      chk("rst_done_valid", done_valid, 0);
      chk("rst_done_err", done_err, 0);
      chk("rst_s_vppn", s_vppn, 0);
      reset = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", req_ready, 1);

      for (int i = 0; i < 10; i++) run_txn(tbl[i].r, tbl[i].e, 1'b0, i % 3);

      // fill wrap: first fill taken with counter at 15, second follows right after
      r = '{5'b00010, 5'd0, 10'd0, 19'd0, 4'd3, 19'd0, 10'd0, 1'b0, 4'd0, 1'b0};
      for (int k = 0; k < 40 && m_rand != 14; k++) @(negedge clk);
      chk("fill_setup", m_rand, 14);
      run_txn(r, ez, 1'b1, 0);
      run_txn(r, ez, 1'b1, 0);

      // flush in the write cycle
      @(negedge clk);
      r = '{5'b00100, 5'd0, 10'd0, 19'd0, 4'd3, 19'd0, 10'd0, 1'b0, 4'd0, 1'b0};
      drive_req(r);
      @(negedge clk);
      req_valid = 1'b0;
      flush = 1'b1;
      #1;
      chk("flush_we", we, 0);
      @(negedge clk);
      flush = 1'b0;
      chk("flush_idle", req_ready, 1);
      chk("flush_no_done", done_valid, 0);
      @(negedge clk);
      chk("flush_no_done2", done_valid, 0);

      // flush during response
      r = '{5'b01000, 5'd0, 10'd0, 19'd0, 4'd2, 19'd0, 10'd0, 1'b0, 4'd0, 1'b1};
      drive_req(r);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      chk("resp_valid", done_valid, 1);
      flush = 1'b1;
      #1;
      chk("flush_resp_gate", done_valid, 0);
      @(negedge clk);
      flush = 1'b0;
      chk("flush_resp_idle", req_ready, 1);

      // flush blocks acceptance
      r = '{5'b10000, 5'd0, 10'd0, 19'd0, 4'd2, 19'd0, 10'd0, 1'b0, 4'd0, 1'b0};
      drive_req(r);
      flush = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      flush = 1'b0;
      chk("flush_no_accept", req_ready, 1);
      @(negedge clk);
      chk("flush_no_accept_done", done_valid, 0);

      // reset while reading
      r = '{5'b01000, 5'd0, 10'd0, 19'd0, 4'd9, 19'd0, 10'd0, 1'b0, 4'd0, 1'b1};
      drive_req(r);
      @(negedge clk);
      req_valid = 1'b0;
      chk("rd_r_index", r_index, 9);
      reset = 1'b1;
      #1;
      chk("rstmid_r_index", r_index, 0);
      chk("rstmid_ready", req_ready, 0);
      chk("rstmid_done", done_valid, 0);
      chk("rstmid_we", we, 0);
      @(negedge clk);
      chk("rstmid_done2", done_valid, 0);
      reset = 1'b0;
      @(negedge clk);
      chk("rstmid_back", req_ready, 1);

      // random requests against the model
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 9) == 0) r.op = 5'($urandom_range(0, 31));
         else                           r.op = 5'(1 << $urandom_range(0, 4));
         r.invop  = 5'($urandom_range(0, 8));
         r.asid   = 10'($urandom);
         r.va     = 19'($urandom);
         r.cidx   = 4'($urandom);
         r.cvppn  = 19'($urandom);
         r.casid  = 10'($urandom);
         r.sfound = 1'($urandom);
         r.sidx   = 4'($urandom);
         r.re     = 1'($urandom);
         run_txn(r, ez, 1'b1, $urandom_range(0, 2));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/tlb_op_seq.md
TLB_OP_SEQ -- requirements
Module: tlb_op_seq

Interface
REQ-001 SHALL have parameter TLBNUM, default 16, number of TLB entries; index width IDXW = log2(TLBNUM) = 4.
REQ-002 SHALL have ports clk in 1 (system clock) and reset in 1 (asynchronous, active-high); one clock domain only.
REQ-003 SHALL have request ports: req_valid in 1; req_ready out 1; req_op in 5 (one-hot: [4] srch, [3] rd, [2] wr, [1] fill, [0] inv); req_invop in 5; req_asid in 10; req_va in 19.
REQ-004 SHALL have CSR ports: csr_tlbidx_index in IDXW; csr_tlbehi_vppn in 19; csr_asid_asid in 10.
REQ-005 SHALL have search/inv port: s_vppn out 19; s_asid out 10; s_found in 1; s_index in IDXW; inv_valid out 1; inv_op out 5.
REQ-006 SHALL have read/write port: r_index out IDXW; r_e in 1; we out 1; w_index out IDXW.
REQ-007 SHALL have response ports: done_valid out 1; done_ready in 1; done_op out 5; done_found out 1; done_index out IDXW; done_re out 1; done_err out 1.
REQ-008 SHALL have flush in 1, which aborts any operation in progress.

Function
REQ-009 SHALL implement FSM states IDLE, SRCH, RD, WR, INV, RESP.
REQ-010 SHALL assert req_ready only in IDLE; the accept edge is the one where req_valid & req_ready & ~flush.
REQ-011 On accept, SHALL capture req_op, req_invop, req_asid, req_va, csr_tlbidx_index, csr_tlbehi_vppn, csr_asid_asid, and rand_idx.
REQ-012 On accept, SHALL transition by op: srch->SRCH, rd->RD, wr/fill->WR, inv->INV.
REQ-013 If req_op is not one-hot, SHALL go IDLE->RESP with done_err=1 and no TLB side effect.
REQ-014 In SRCH, SHALL drive s_vppn/s_asid from the captured CSR values; SHALL register s_found and s_index at the end of the cycle; ->RESP.
REQ-015 In RD, SHALL drive r_index = captured tlbidx_index; SHALL register r_e; ->RESP.
REQ-016 In WR, SHALL assert we for exactly one cycle; w_index = captured tlbidx_index (wr) or captured rand_idx (fill); ->RESP.
REQ-017 In INV with captured invop <= 6: SHALL assert inv_valid for one cycle, inv_op = invop, s_asid = captured req_asid, s_vppn = captured req_va; ->RESP.
REQ-018 In INV with captured invop > 6: SHALL assert no inv_valid, set done_err=1, ->RESP.
REQ-019 In RESP, SHALL hold done_valid=1 with stable done_* fields until done_ready; on done_ready ->IDLE.
REQ-020 SHALL hold done_found and done_re at 0 for ops that do not produce them.
REQ-021 Latency: accept edge at cycle 0, TLB action in cycle 1, done_valid from cycle 2; minimum 3 cycles per op; back-to-back accept in the same cycle as done handshake is not allowed.
REQ-022 rand_idx SHALL be a free-running IDXW counter, +1 every cycle, wrapping TLBNUM-1 -> 0.
REQ-023 flush SHALL force IDLE at the next edge from any state.
REQ-024 flush SHALL combinationally gate we, inv_valid and done_valid to 0 in the same cycle.
REQ-025 flush SHALL block accept in the same cycle.
REQ-026 s_*, r_index, w_index and inv_op SHALL be 0 when unused.

Reset
REQ-027 Asynchronous reset SHALL force state IDLE, rand_idx=0, all captured registers=0.
REQ-028 Output values under reset: req_ready=1 (once reset deasserted); we=inv_valid=done_valid=done_err=0; all other outputs 0.
REQ-029 Reset asserted mid-operation SHALL abandon the operation with no we or inv_valid pulse after assertion.

Structure
REQ-030 Shared package SHALL hold op bit positions, state enum, INVOP_MAX=6, and port widths (19, 10, 5).
REQ-031 SHALL instantiate one sub-module, tlb_rand_idx (the rand_idx counter), parameterized by TLBNUM.

Verification
REQ-032 Scenario (srch): tlbehi_vppn=0x12345, asid=0x3, TLB returns found=1, index=5 -> done_valid cycle 2, done_found=1, done_index=5.
REQ-033 Scenario (fill): accept when rand_idx=15 -> we pulse cycle 1 with w_index=15; next fill accepted 3 cycles later uses w_index=2 (wrap).
REQ-034 Scenario (inv): invop=7 -> no inv_valid, done_err=1; invop=5, asid=0x2A, va=0x00ABC -> one inv_valid cycle with those values.
REQ-035 Scenario (bad op): req_op=5'b00110 -> no we, done_err=1 at cycle 1; held until done_ready.
REQ-036 Scenario (flush): flush in the WR cycle -> we=0, IDLE next cycle, no done_valid; reset asserted in RD -> all outputs 0 immediately.
